drp_reconf_ctrl: RTL and testbench

// - DRP master that drives the PLL DRP register file (DADDR/DEN/DWE/DI, DO/DRDY) to apply one of two

---
 rtl/drp_reconf_ctrl_pkg.sv | 46 ++++
 rtl/drp_reconf_ctrl_rom.sv | 23 ++
 rtl/drp_reconf_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_drp_reconf_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/drp_reconf_ctrl_pkg.sv
// Shared DRP definitions: register map, table entry layout
// and controller state encodings.
package drp_reconf_ctrl_pkg;

  localparam int ADDR_W  = 7;
  localparam int MASK_W  = 16;
  localparam int DATA_W  = 16;
  localparam int ENTRY_W = ADDR_W + MASK_W + DATA_W;
  localparam int IDX_W   = 5;

  localparam logic [ADDR_W-1:0] CLKREG1_0  = 7'h08;
  localparam logic [ADDR_W-1:0] CLKREG2_0  = 7'h09;
  localparam logic [ADDR_W-1:0] CLKREG1_1  = 7'h0A;
  localparam logic [ADDR_W-1:0] CLKREG2_1  = 7'h0B;
  localparam logic [ADDR_W-1:0] CLKREG1_2  = 7'h0C;
  localparam logic [ADDR_W-1:0] CLKREG2_2  = 7'h0D;
  localparam logic [ADDR_W-1:0] CLKREG1_FB = 7'h14;
  localparam logic [ADDR_W-1:0] CLKREG2_FB = 7'h15;
  localparam logic [ADDR_W-1:0] DIVREG     = 7'h16;
  localparam logic [ADDR_W-1:0] LOCKREG1   = 7'h18;
  localparam logic [ADDR_W-1:0] LOCKREG2   = 7'h19;
  localparam logic [ADDR_W-1:0] LOCKREG3   = 7'h1A;
  localparam logic [ADDR_W-1:0] POWERREG   = 7'h28;
  localparam logic [ADDR_W-1:0] FILTREG1   = 7'h4E;
  localparam logic [ADDR_W-1:0] FILTREG2   = 7'h4F;

  // Field order matches the packed table: addr in the top bits.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } drp_entry_t;

  typedef enum logic [3:0] {
    ST_RESTART     = 4'd0,
    ST_WAIT_LOCK   = 4'd1,
    ST_WAIT_SEL    = 4'd2,
    ST_ADDRESS     = 4'd3,
    ST_WAIT_A_DRDY = 4'd4,
    ST_BITMASK     = 4'd5,
    ST_BITSET      = 4'd6,
    ST_WRITE       = 4'd7,
    ST_WAIT_DRDY   = 4'd8
  } state_t;

endpackage

// File: rtl/drp_reconf_ctrl_rom.sv
// Combinational table mux: picks one entry of the selected
// reconfiguration table by index.
module drp_reconf_ctrl_rom
  import drp_reconf_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 9,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0] S1_TABLE = '0,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0] S2_TABLE = '0
) (
  input  logic             ssel,
  input  logic [IDX_W-1:0] idx,
  output drp_entry_t       entry
);

  always_comb begin
    entry = '0;
    if (int'(idx) < NUM_ENTRIES) begin
      if (ssel) entry = S2_TABLE[int'(idx)*ENTRY_W +: ENTRY_W];
      else      entry = S1_TABLE[int'(idx)*ENTRY_W +: ENTRY_W];
    end
  end

endmodule

// File: rtl/drp_reconf_ctrl.sv
// DRP master applying one of two stored read-modify-write
// tables to the PLL, holding it in reset while doing so.
module drp_reconf_ctrl
  import drp_reconf_ctrl_pkg::*;
#(
  parameter int NUM_ENTRIES = 9,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0] S1_TABLE = '0,
  parameter logic [NUM_ENTRIES*ENTRY_W-1:0] S2_TABLE = '0,
  parameter int DRDY_TIMEOUT = 64
) (
  input  logic              DCLK,
  input  logic              RST,
  input  logic              SEN,
  input  logic              SSEL,
  input  logic              LOCKED,
  input  logic [DATA_W-1:0] DO,
  input  logic              DRDY,
  output logic [ADDR_W-1:0] DADDR,
  output logic [DATA_W-1:0] DI,
  output logic              DEN,
  output logic              DWE,
  output logic              RST_PLL,
  output logic              SRDY,
  output logic              ERR
);

  localparam int TMR_W = $clog2(DRDY_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DRDY_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ENTRIES - 1);

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              ssel_q, ssel_d;
  logic [DATA_W-1:0] rmw_q, rmw_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              seen0_q, seen0_d;
  logic [ADDR_W-1:0] daddr_q, daddr_d;
  logic [DATA_W-1:0] di_q, di_d;
  logic              den_q, den_d;
  logic              dwe_q, dwe_d;
  logic              rst_pll_q, rst_pll_d;
  logic              srdy_q, srdy_d;
  logic              err_q, err_d;

  drp_entry_t        ent;
  logic              done;

  drp_reconf_ctrl_rom #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .S1_TABLE    (S1_TABLE),
    .S2_TABLE    (S2_TABLE)
  ) u_drp_rom (
    .ssel  (ssel_q),
    .idx   (idx_q),
    .entry (ent)
  );

  // A stale DRDY=1 right after DEN is ignored: need a 0 first.
  assign done = DRDY && seen0_q;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ssel_d    = ssel_q;
    rmw_d     = rmw_q;
    timer_d   = timer_q;
    seen0_d   = seen0_q;
    daddr_d   = daddr_q;
    di_d      = di_q;
    den_d     = 1'b0;
    dwe_d     = dwe_q;
    rst_pll_d = rst_pll_q;
    srdy_d    = 1'b0;
    err_d     = err_q;
    unique case (state_q)
      ST_RESTART: begin
        rst_pll_d = 1'b0;
        state_d   = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        rst_pll_d = 1'b0;
        if (LOCKED) begin
          srdy_d  = 1'b1;
          state_d = ST_WAIT_SEL;
        end
      end
      ST_WAIT_SEL: begin
        if (SEN) begin
          ssel_d    = SSEL;
          idx_d     = '0;
          rst_pll_d = 1'b1;
          state_d   = ST_ADDRESS;
        end
      end
      ST_ADDRESS: begin
        if (DRDY) begin
          daddr_d = ent.addr;
          den_d   = 1'b1;
          dwe_d   = 1'b0;
          timer_d = '0;
          seen0_d = 1'b0;
          state_d = ST_WAIT_A_DRDY;
        end
      end
      ST_BITMASK: begin
        rmw_d   = rmw_q & ent.mask;
        state_d = ST_BITSET;
      end
      ST_BITSET: begin
        rmw_d   = rmw_q | (ent.data & ~ent.mask);
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (DRDY) begin
          daddr_d = ent.addr;
          di_d    = rmw_q;
          den_d   = 1'b1;
          dwe_d   = 1'b1;
          timer_d = '0;
          seen0_d = 1'b0;
          state_d = ST_WAIT_DRDY;
        end
      end
      ST_WAIT_A_DRDY, ST_WAIT_DRDY: begin
        if (!DRDY) seen0_d = 1'b1;
        if (done) begin
          if (state_q == ST_WAIT_A_DRDY) begin
            rmw_d   = DO;
            state_d = ST_BITMASK;
          end else if (idx_q == IDX_LAST) begin
            rst_pll_d = 1'b0;
            state_d   = ST_WAIT_LOCK;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = ST_ADDRESS;
          end
        end else if (timer_q == TMR_LAST) begin
          err_d     = 1'b1;
          rst_pll_d = 1'b1;
          state_d   = ST_RESTART;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      default: begin
        state_d = ST_RESTART;
      end
    endcase
  end

  always_ff @(posedge DCLK) begin
    if (RST) begin
      state_q   <= ST_RESTART;
      idx_q     <= '0;
      ssel_q    <= 1'b0;
      rmw_q     <= '0;
      timer_q   <= '0;
      seen0_q   <= 1'b0;
      daddr_q   <= '0;
      di_q      <= '0;
      den_q     <= 1'b0;
      dwe_q     <= 1'b0;
      rst_pll_q <= 1'b1;
      srdy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      ssel_q    <= ssel_d;
      rmw_q     <= rmw_d;
      timer_q   <= timer_d;
      seen0_q   <= seen0_d;
      daddr_q   <= daddr_d;
      di_q      <= di_d;
      den_q     <= den_d;
      dwe_q     <= dwe_d;
      rst_pll_q <= rst_pll_d;
      srdy_q    <= srdy_d;
      err_q     <= err_d;
    end
  end

  assign DADDR   = daddr_q;
  assign DI      = di_q;
  assign DEN     = den_q;
  assign DWE     = dwe_q;
  assign RST_PLL = rst_pll_q;
  assign SRDY    = srdy_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_drp_reconf_ctrl.sv
// Directed bench: DRP slave model with a LOCKED stub, checking
// RMW results, ordering, timeout, reset abort and SEN filtering.
module tb_drp_reconf_ctrl;

  localparam logic [116:0] S1 = {
    7'h14, 16'h0000, 16'h1234,
    7'h09, 16'hFF00, 16'h0012,
    7'h08, 16'hF000, 16'h0041
  };
  localparam logic [116:0] S2 = {
    7'h16, 16'hFF0F, 16'h00C0,
    7'h09, 16'hF0F0, 16'h0A0B,
    7'h08, 16'h00FF, 16'hBE00
  };

  logic        clk = 1'b0;
  logic        rst, sen, ssel, locked;
  logic [15:0] do_r;
  logic        drdy;
  logic [6:0]  daddr;
  logic [15:0] di;
  logic        den, dwe, rst_pll, srdy, err;

  logic        hang, init_req;
  logic [15:0] regs [0:127];
  logic [6:0]  rd_addr;
  int          cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          last_den = -100;
  logic [6:0]  q_addr [$];
  logic        q_we [$];
  logic [15:0] q_di [$];

  always #5 clk = ~clk;

  drp_reconf_ctrl #(
    .NUM_ENTRIES  (3),
    .S1_TABLE     (S1),
    .S2_TABLE     (S2),
    .DRDY_TIMEOUT (64)
  ) dut (
    .DCLK    (clk),
    .RST     (rst),
    .SEN     (sen),
    .SSEL    (ssel),
    .LOCKED  (locked),
    .DO      (do_r),
    .DRDY    (drdy),
    .DADDR   (daddr),
    .DI      (di),
    .DEN     (den),
    .DWE     (dwe),
    .RST_PLL (rst_pll),
    .SRDY    (srdy),
    .ERR     (err)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // DRP slave: DRDY drops after DEN and returns one cycle later.
  always @(posedge clk) begin
    if (init_req) begin
      for (int i = 0; i < 128; i++) regs[i] <= 16'h0000;
      regs[7'h08] <= 16'hA5C3;
      regs[7'h09] <= 16'h1357;
      regs[7'h14] <= 16'hFFFF;
      regs[7'h16] <= 16'hCAFE;
      drdy <= 1'b1;
      do_r <= 16'h0000;
      cnt  <= 0;
    end else if (den) begin
      drdy    <= 1'b0;
      rd_addr <= daddr;
      if (dwe) regs[daddr] <= di;
      cnt <= hang ? 0 : 1;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        drdy <= 1'b1;
        do_r <= regs[rd_addr];
      end
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (den) begin
      q_addr.push_back(daddr);
      q_we.push_back(dwe);
      q_di.push_back(di);
      check("den_gap", 32'(cyc - last_den >= 4), 1);
      check("rst_pll_at_den", 32'(rst_pll), 1);
      last_den = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_srdy(input int bound, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (srdy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic reinit();
    init_req = 1'b1;
    tick();
    init_req = 1'b0;
  endtask

  // One full table run with SEN noise while busy and while unlocked.
  task automatic run_seq(input logic sel, output int base);
    logic ok;
    int   ns;
    reinit();
    base   = q_addr.size();
    locked = 1'b0;
    sen    = 1'b1;
    ssel   = sel;
    tick();
    sen = 1'b0;
    repeat (5) tick();
    sen  = 1'b1;
    ssel = ~sel;
    tick();
    sen = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (!rst_pll) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("seq_end", 32'(ok), 1);
    sen = 1'b1;
    tick();
    sen = 1'b0;
    ns  = 0;
    repeat (10) begin
      tick();
      if (srdy) ns++;
    end
    check("srdy_unlocked", 32'(ns), 0);
    locked = 1'b1;
    wait_srdy(10, ok);
    check("srdy_locked", 32'(ok), 1);
    repeat (20) tick();
    check("den_count", 32'(q_addr.size() - base), 6);
  endtask

  initial begin : main
    logic        ok;
    int          base, ns, nw, k;
    logic [6:0]  exp_a [6];
    logic [15:0] exp_w [3];

    rst = 1'b1; sen = 1'b0; ssel = 1'b0; locked = 1'b0;
    hang = 1'b0; init_req = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    check("rst_den", 32'(den), 0);
    check("rst_rst_pll", 32'(rst_pll), 1);
    check("rst_daddr", 32'(daddr), 0);
    check("rst_di", 32'(di), 0);
    check("rst_srdy", 32'(srdy), 0);
    check("rst_err", 32'(err), 0);

    init_req = 1'b0;
    rst = 1'b0;
    check("restart_rst_pll", 32'(rst_pll), 1);
    tick();
    check("wait_lock_rst_pll", 32'(rst_pll), 0);
    ns = 0;
    repeat (3) begin
      tick();
      if (srdy) ns++;
    end
    check("srdy_before_lock", 32'(ns), 0);
    locked = 1'b1;
    ns = 0;
    repeat (10) begin
      tick();
      if (srdy) ns++;
    end
    check("srdy_once", 32'(ns), 1);
    check("no_den_after_lock", 32'(q_addr.size()), 0);

    run_seq(1'b0, base);
    check("s1_rd_addr", 32'(q_addr[base]), 32'h08);
    check("s1_rd_we", 32'(q_we[base]), 0);
    check("s1_wr_addr", 32'(q_addr[base+1]), 32'h08);
    check("s1_wr_we", 32'(q_we[base+1]), 1);
    check("s1_wr_di", 32'(q_di[base+1]), 32'hA041);
    check("s1_reg09", 32'(regs[7'h09]), 32'h1312);
    check("s1_reg14", 32'(regs[7'h14]), 32'h1234);

    run_seq(1'b1, base);
    exp_a = '{7'h08, 7'h08, 7'h09, 7'h09, 7'h16, 7'h16};
    exp_w = '{16'hBEC3, 16'h1A5B, 16'hCACE};
    for (int i = 0; i < 6; i++) begin
      check("s2_addr", 32'(q_addr[base+i]), 32'(exp_a[i]));
      check("s2_we", 32'(q_we[base+i]), 32'(i % 2));
      if (i % 2 == 1)
        check("s2_di", 32'(q_di[base+i]), 32'(exp_w[i/2]));
    end
    check("s2_reg16", 32'(regs[7'h16]), 32'hCACE);

    reinit();
    hang   = 1'b1;
    locked = 1'b0;
    sen    = 1'b1;
    ssel   = 1'b0;
    tick();
    sen = 1'b0;
    ok  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (den) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    check("to_den_seen", 32'(ok), 1);
    k = 0;
    while (!err && k < 200) begin
      tick();
      k++;
    end
    check("to_cycles", 32'(k), 64);
    check("to_restart_rst_pll", 32'(rst_pll), 1);
    tick();
    check("to_wait_lock_rst_pll", 32'(rst_pll), 0);
    hang = 1'b0;
    reinit();
    locked = 1'b1;
    wait_srdy(10, ok);
    check("to_srdy", 32'(ok), 1);
    run_seq(1'b0, base);
    check("err_sticky", 32'(err), 1);

    reinit();
    locked = 1'b0;
    sen    = 1'b1;
    ssel   = 1'b1;
    tick();
    sen = 1'b0;
    nw  = 0;
    for (int i = 0; i < 100; i++) begin
      if (den && dwe) nw++;
      if (nw == 2) break;
      tick();
    end
    check("mid_wr_seen", 32'(nw), 2);
    rst = 1'b1;
    tick();
    check("mid_daddr", 32'(daddr), 0);
    check("mid_di", 32'(di), 0);
    check("mid_den", 32'(den), 0);
    check("mid_dwe", 32'(dwe), 0);
    check("mid_srdy", 32'(srdy), 0);
    check("mid_err", 32'(err), 0);
    check("mid_rst_pll", 32'(rst_pll), 1);
    check("mid_reg08_kept", 32'(regs[7'h08]), 32'hBEC3);
    rst = 1'b0;
    locked = 1'b1;
    wait_srdy(10, ok);
    check("mid_srdy_after", 32'(ok), 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
